// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between decode/writeback units and the register-file write controller.
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          en_i;
  logic          wb0_valid_i;
  logic [AW-1:0] wb0_sel_i;
  logic [DW-1:0] wb0_data_i;
  logic          wb0_ready_o;
  logic          wb1_valid_i;
  logic [AW-1:0] wb1_sel_i;
  logic [DW-1:0] wb1_data_i;
  logic          wb1_ready_o;
  logic          issue_i;
  logic [AW-1:0] issue_sel_i;
  logic [AW-1:0] rd_a_sel_i;
  logic [AW-1:0] rd_b_sel_i;
  logic          hazard_o;
  logic          issue_stall_o;
  logic          rf_en_o;
  logic          rf_wr_o;
  logic [AW-1:0] rf_wr_sel_o;
  logic [DW-1:0] rf_ld_o;
  logic          init_done_o;

  modport slave (
    input  en_i, wb0_valid_i, wb0_sel_i, wb0_data_i,
    input  wb1_valid_i, wb1_sel_i, wb1_data_i,
    input  issue_i, issue_sel_i, rd_a_sel_i, rd_b_sel_i,
    output wb0_ready_o, wb1_ready_o, hazard_o, issue_stall_o,
    output rf_en_o, rf_wr_o, rf_wr_sel_o, rf_ld_o, init_done_o
  );

  modport master (
    output en_i, wb0_valid_i, wb0_sel_i, wb0_data_i,
    output wb1_valid_i, wb1_sel_i, wb1_data_i,
    output issue_i, issue_sel_i, rd_a_sel_i, rd_b_sel_i,
    input  wb0_ready_o, wb1_ready_o, hazard_o, issue_stall_o,
    input  rf_en_o, rf_wr_o, rf_wr_sel_o, rf_ld_o, init_done_o
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// Register-file write controller: post-reset zero-fill, two-port round-robin
// writeback arbitration and a pending-write scoreboard for decode hazards.
`default_nettype none

module regfile_wb_arbiter #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [0:0]    S_CLEAR   = 1'b0;
  localparam logic [0:0]    S_RUN     = 1'b1;
  localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [AW-1:0]    fill_cnt;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             last_grant;
  logic             last_grant_next;
  logic             grant0;
  logic             grant1;
  logic             run_en;

  logic          rf_en;
  logic          rf_wr;
  logic [AW-1:0] rf_wr_sel;
  logic [DW-1:0] rf_ld;
  logic          init_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_CLEAR && fill_cnt == LAST_REG) state_next = S_RUN;
  end

  // last_grant only moves on a tie, so a lone request never disturbs the rotation.
  always_comb begin
    run_en          = (state == S_RUN) && bus.en_i;
    grant0          = run_en && bus.wb0_valid_i && (!bus.wb1_valid_i || last_grant);
    grant1          = run_en && bus.wb1_valid_i && (!bus.wb0_valid_i || !last_grant);
    last_grant_next = last_grant;
    if (run_en && bus.wb0_valid_i && bus.wb1_valid_i) last_grant_next = grant1;

    busy_next = busy;
    if (grant0)                busy_next[bus.wb0_sel_i]   = 1'b0;
    if (grant1)                busy_next[bus.wb1_sel_i]   = 1'b0;
    if (run_en && bus.issue_i) busy_next[bus.issue_sel_i] = 1'b1;

    bus.wb0_ready_o   = grant0;
    bus.wb1_ready_o   = grant1;
    bus.hazard_o      = (state == S_RUN) && (busy[bus.rd_a_sel_i] || busy[bus.rd_b_sel_i]);
    bus.issue_stall_o = (state == S_RUN) && busy[bus.issue_sel_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_cnt   <= '0;
      busy       <= '0;
      last_grant <= 1'b1;
      rf_en      <= 1'b0;
      rf_wr      <= 1'b0;
      rf_wr_sel  <= '0;
      rf_ld      <= '0;
      init_done  <= 1'b0;
    end else if (state == S_CLEAR) begin
      fill_cnt  <= fill_cnt + AW'(1);
      rf_en     <= 1'b1;
      rf_wr     <= 1'b1;
      rf_wr_sel <= fill_cnt;
      rf_ld     <= '0;
    end else begin
      busy       <= busy_next;
      last_grant <= last_grant_next;
      rf_en      <= bus.en_i;
      init_done  <= 1'b1;
      rf_wr      <= grant0 || grant1;
      if (grant0) begin
        rf_wr_sel <= bus.wb0_sel_i;
        rf_ld     <= bus.wb0_data_i;
      end else if (grant1) begin
        rf_wr_sel <= bus.wb1_sel_i;
        rf_ld     <= bus.wb1_data_i;
      end
    end
  end

  assign bus.rf_en_o     = rf_en;
  assign bus.rf_wr_o     = rf_wr;
  assign bus.rf_wr_sel_o = rf_wr_sel;
  assign bus.rf_ld_o     = rf_ld;
  assign bus.init_done_o = init_done;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: fill sequence, arbitration, scoreboard, enable and reset.
`default_nettype none

module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_wb_arbiter_if #(.AW(5), .DW(16)) bus ();

  regfile_wb_arbiter #(.NREGS(32), .AW(5), .DW(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wb0_valid_i = 1'b0; bus.wb0_sel_i = '0; bus.wb0_data_i = '0;
    bus.wb1_valid_i = 1'b0; bus.wb1_sel_i = '0; bus.wb1_data_i = '0;
    bus.issue_i = 1'b0; bus.issue_sel_i = '0;
    bus.rd_a_sel_i = '0; bus.rd_b_sel_i = '0;
  endtask

  // Fill sequence: sel 0..31 on consecutive cycles, requests held high must not be granted.
  task automatic check_fill();
    for (int i = 0; i < 32; i++) begin
      cycle();
      check("fill_wr", 32'(bus.rf_wr_o), 32'd1);
      check("fill_en", 32'(bus.rf_en_o), 32'd1);
      check("fill_sel", 32'(bus.rf_wr_sel_o), 32'(i));
      check("fill_ld", 32'(bus.rf_ld_o), 32'd0);
      check("fill_done_low", 32'(bus.init_done_o), 32'd0);
      if (i < 31) begin
        #1;
        check("fill_ready0", 32'(bus.wb0_ready_o), 32'd0);
        check("fill_ready1", 32'(bus.wb1_ready_o), 32'd0);
        check("fill_hazard", 32'(bus.hazard_o), 32'd0);
        if (i == 30) idle_inputs();
      end
    end
    cycle();
    check("init_done", 32'(bus.init_done_o), 32'd1);
    check("post_fill_wr", 32'(bus.rf_wr_o), 32'd0);
  endtask

  initial begin
    idle_inputs();
    bus.en_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(bus.rf_en_o), 32'd0);
    check("rst_wr", 32'(bus.rf_wr_o), 32'd0);
    check("rst_sel", 32'(bus.rf_wr_sel_o), 32'd0);
    check("rst_ld", 32'(bus.rf_ld_o), 32'd0);
    check("rst_done", 32'(bus.init_done_o), 32'd0);

    // Requests, issue and disabled enable during fill must all be ignored.
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd4;
    bus.wb1_valid_i = 1'b1; bus.wb1_sel_i = 5'd6;
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd8; bus.rd_a_sel_i = 5'd8;
    bus.en_i = 1'b0;
    rst = 1'b0;
    check_fill();
    bus.en_i = 1'b1;
    #1;
    check("issue_in_fill_ignored", 32'(bus.hazard_o), 32'd0);

    // Single requester.
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd5; bus.wb0_data_i = 16'hBEEF;
    #1;
    check("single_ready0", 32'(bus.wb0_ready_o), 32'd1);
    check("single_ready1", 32'(bus.wb1_ready_o), 32'd0);
    cycle();
    idle_inputs();
    check("single_wr", 32'(bus.rf_wr_o), 32'd1);
    check("single_sel", 32'(bus.rf_wr_sel_o), 32'd5);
    check("single_ld", 32'(bus.rf_ld_o), 32'hBEEF);
    check("single_en", 32'(bus.rf_en_o), 32'd1);

    // Sustained tie: grants alternate starting at port 0.
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd1; bus.wb0_data_i = 16'h1111;
    bus.wb1_valid_i = 1'b1; bus.wb1_sel_i = 5'd2; bus.wb1_data_i = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_ready0", 32'(bus.wb0_ready_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("tie_ready1", 32'(bus.wb1_ready_o), (k % 2 == 1) ? 32'd1 : 32'd0);
      cycle();
      check("tie_sel", 32'(bus.rf_wr_sel_o), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("tie_ld", 32'(bus.rf_ld_o), (k % 2 == 0) ? 32'h1111 : 32'h2222);
    end
    idle_inputs();
    cycle();
    check("idle_wr", 32'(bus.rf_wr_o), 32'd0);
    check("idle_sel_hold", 32'(bus.rf_wr_sel_o), 32'd2);
    check("idle_ld_hold", 32'(bus.rf_ld_o), 32'h2222);

    // RAW hazard on r7 cleared by a port-1 writeback.
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd7;
    #1;
    check("stall_before_issue", 32'(bus.issue_stall_o), 32'd0);
    cycle();
    bus.issue_i = 1'b0;
    bus.rd_a_sel_i = 5'd7; bus.rd_b_sel_i = 5'd0;
    #1;
    check("hazard_a", 32'(bus.hazard_o), 32'd1);
    check("stall_r7", 32'(bus.issue_stall_o), 32'd1);
    bus.rd_a_sel_i = 5'd0; bus.rd_b_sel_i = 5'd7;
    #1;
    check("hazard_b", 32'(bus.hazard_o), 32'd1);
    cycle();
    bus.wb1_valid_i = 1'b1; bus.wb1_sel_i = 5'd7; bus.wb1_data_i = 16'h7777;
    #1;
    check("r7_ready1", 32'(bus.wb1_ready_o), 32'd1);
    check("hazard_during_grant", 32'(bus.hazard_o), 32'd1);
    cycle();
    bus.wb1_valid_i = 1'b0;
    #1;
    check("hazard_cleared", 32'(bus.hazard_o), 32'd0);
    check("stall_cleared", 32'(bus.issue_stall_o), 32'd0);
    check("r7_sel", 32'(bus.rf_wr_sel_o), 32'd7);
    check("r7_ld", 32'(bus.rf_ld_o), 32'h7777);

    // Set beats clear on the same index.
    idle_inputs();
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd3;
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd3; bus.wb0_data_i = 16'h3333;
    #1;
    check("r3_ready0", 32'(bus.wb0_ready_o), 32'd1);
    cycle();
    idle_inputs();
    bus.rd_a_sel_i = 5'd3; bus.issue_sel_i = 5'd3;
    #1;
    check("set_wins_hazard", 32'(bus.hazard_o), 32'd1);
    check("set_wins_stall", 32'(bus.issue_stall_o), 32'd1);
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd3;
    cycle();
    bus.wb0_valid_i = 1'b0;
    #1;
    check("r3_cleared", 32'(bus.hazard_o), 32'd0);

    // Pipeline disabled: no grant, no scoreboard set, enable drops.
    idle_inputs();
    bus.en_i = 1'b0;
    bus.wb0_valid_i = 1'b1; bus.wb0_sel_i = 5'd9; bus.wb0_data_i = 16'h9999;
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd10;
    #1;
    check("dis_ready0", 32'(bus.wb0_ready_o), 32'd0);
    cycle();
    check("dis_rf_en", 32'(bus.rf_en_o), 32'd0);
    check("dis_rf_wr", 32'(bus.rf_wr_o), 32'd0);
    bus.issue_i = 1'b0; bus.rd_a_sel_i = 5'd10;
    #1;
    check("dis_no_set", 32'(bus.hazard_o), 32'd0);

    // Reset in the middle of a grant; busy r12 must also be forgotten.
    bus.en_i = 1'b1;
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd12;
    #1;
    check("mid_ready0", 32'(bus.wb0_ready_o), 32'd1);
    cycle();
    check("mid_wr", 32'(bus.rf_wr_o), 32'd1);
    check("mid_ld", 32'(bus.rf_ld_o), 32'h9999);
    #2 rst = 1'b1;
    #1;
    check("async_wr", 32'(bus.rf_wr_o), 32'd0);
    check("async_en", 32'(bus.rf_en_o), 32'd0);
    check("async_sel", 32'(bus.rf_wr_sel_o), 32'd0);
    check("async_ld", 32'(bus.rf_ld_o), 32'd0);
    check("async_ready0", 32'(bus.wb0_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_fill();
    bus.rd_a_sel_i = 5'd12; bus.issue_sel_i = 5'd12;
    #1;
    check("busy_reset", 32'(bus.hazard_o), 32'd0);
    check("stall_reset", 32'(bus.issue_stall_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controller in front of the 32x16 register file. It owns the register file's single write port and enable, and sequences a zero-fill of all registers after reset, because the register file does not clear itself. After the fill it round-robin arbitrates two writeback requesters (port 0 = ALU, port 1 = load unit) onto the write port. It also keeps a pending-write scoreboard so decode can stall on read-after-write and write-after-write hazards.

Parameters:
NREGS, 32, number of architectural registers
AW, 5, register select width (log2 NREGS)
DW, 16, data width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
en_i  in  1  pipeline enable; low = freeze writes and drop register file enable
wb0_valid_i  in  1  port 0 writeback request
wb0_sel_i  in  AW  port 0 destination register
wb0_data_i  in  DW  port 0 write data
wb0_ready_o  out  1  port 0 grant; combinational
wb1_valid_i  in  1  port 1 writeback request
wb1_sel_i  in  AW  port 1 destination register
wb1_data_i  in  DW  port 1 write data
wb1_ready_o  out  1  port 1 grant; combinational
issue_i  in  1  decode issues an instruction writing issue_sel_i
issue_sel_i  in  AW  destination of the issuing instruction
rd_a_sel_i  in  AW  source A register being decoded
rd_b_sel_i  in  AW  source B register being decoded
hazard_o  out  1  a source register has a pending write; combinational
issue_stall_o  out  1  the destination register already has a pending write; combinational
rf_en_o  out  1  to register file en_i; registered
rf_wr_o  out  1  to register file wr_i; registered
rf_wr_sel_o  out  AW  to register file wr_sel_i; registered
rf_ld_o  out  DW  to register file reg_ld_i; registered
init_done_o  out  1  high once the zero-fill completes; registered

Behaviour:
- Reset (asynchronous, any cycle, including mid-fill or mid-grant):
  - state=CLEAR, fill counter=0, busy[NREGS-1:0]=0, last_grant=1.
  - rf_en_o=0, rf_wr_o=0, rf_wr_sel_o=0, rf_ld_o=0, init_done_o=0.
- CLEAR state:
  - Each cycle registers rf_en_o=1, rf_wr_o=1, rf_wr_sel_o=counter, rf_ld_o=0, then increments the counter. en_i is ignored.
  - When the counter reaches NREGS-1, the next state is RUN and init_done_o=1. The fill takes exactly NREGS cycles after reset deassertion.
  - wb*_ready_o=0, hazard_o=0 and issue_stall_o=0 throughout. issue_i is ignored.
- RUN state (terminal until the next reset):
  - Arbitration is combinational in cycle N and applies only when en_i=1:
    - One valid port: that port is granted.
    - Both ports valid: the port that is not last_grant wins, and last_grant updates to the winner.
    - The first tie after reset goes to port 0.
  - With en_i=0: both ready outputs are 0 and last_grant holds.
  - Handshake: a transfer happens when valid and ready are both high. Requesters hold sel and data stable while valid is high and ready is low.
  - Write latency: a grant in cycle N registers rf_wr_o=1 with the granted sel and data, visible in cycle N+1. The register file commits at the edge ending cycle N+1.
  - No grant in cycle N gives rf_wr_o=0 in N+1; rf_wr_sel_o and rf_ld_o hold their previous values.
  - rf_en_o is en_i registered.
- Scoreboard:
  - issue_i=1 in RUN with en_i=1 sets busy[issue_sel_i].
  - A granted writeback clears busy[sel].
  - Set and clear of the same index in the same cycle: set wins.
  - Granted writes to non-busy registers are legal and leave busy unchanged.
  - hazard_o = busy[rd_a_sel_i] | busy[rd_b_sel_i].
  - issue_stall_o = busy[issue_sel_i]. Decode must not assert issue_i while issue_stall_o=1; if it does, busy stays 1 (no counting).
- The same destination on both ports in one cycle: only the winner is granted. The loser keeps waiting.

Test Plan:
- Reset, then release -> rf_wr_o=1 for exactly 32 cycles with rf_wr_sel_o=0..31 and rf_ld_o=0; init_done_o rises on the cycle after sel=31; ready outputs stay 0 throughout.
- RUN, wb0 valid with sel=5, data=0xBEEF -> wb0_ready_o=1 in the same cycle; the next cycle shows rf_wr_o=1, rf_wr_sel_o=5, rf_ld_o=0xBEEF.
- Both ports valid for 4 cycles (wb0 sel=1, wb1 sel=2) -> grants alternate 0,1,0,1; the first tie goes to port 0.
- issue_i with sel=7, then rd_a_sel_i=7 -> hazard_o=1 until wb1 is granted for sel=7; 0 the cycle after the grant; issue_stall_o=1 for issue_sel_i=7 in between.
- issue_i sel=3 in the same cycle as a granted wb0 sel=3 -> busy[3] remains 1.
- en_i=0 with wb0 valid -> wb0_ready_o=0 and rf_en_o=0 on the next cycle; assert rst_i mid-grant -> outputs clear immediately and the 32-cycle fill restarts.
